// File: rtl/freelist_mp.sv
// Multi-port circular physical-register free list with branch checkpoints.
// Optional duplicate-free detection is enabled by defining FREELIST_DUPCHK_EN.
module freelist_mp #(
  parameter int WIDTH     = 7,
  parameter int DEPTH     = 32,
  parameter int WAYS      = 4,
  parameter int STNUM     = 1,
  parameter int WIDTH_BRM = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [WAYS-1:0]           i_re,
  output logic [WAYS*WIDTH-1:0]     o_data,
  output logic                      o_ready,
  input  logic [WAYS-1:0]           i_we,
  input  logic [WAYS*WIDTH-1:0]     i_data,
  input  logic                      i_ckpt_en,
  input  logic [WIDTH_BRM-1:0]      i_ckpt_id,
  input  logic                      i_kill,
  input  logic [WIDTH_BRM-1:0]      i_kill_id,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int NCK = 2 ** WIDTH_BRM;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head_reg, tail_reg;
  logic [PW-1:0]    ckpt_reg [NCK];
  logic             err_reg;

  logic [PW-1:0]    re_ofs [WAYS];
  logic [PW-1:0]    we_ofs [WAYS];
  logic [PW-1:0]    pop_re, pop_we, count_w, head_alloc;
  logic             alloc_ok, overflow, dup_err;

  assign pop_re   = PW'($countones(i_re));
  assign pop_we   = PW'($countones(i_we));
  assign count_w  = tail_reg - head_reg;
  assign o_count  = count_w;
  assign o_ready  = (count_w >= PW'(WAYS));
  assign o_err    = err_reg;
  assign alloc_ok = o_ready && !i_kill;
  // Head after this cycle's allocation; this is what a checkpoint captures.
  assign head_alloc = alloc_ok ? (head_reg + pop_re) : head_reg;
  assign overflow   = ({1'b0, count_w} + {1'b0, pop_we}) > (PW+1)'(DEPTH);

  // Lanes are compacted: each active lane takes the next slot after lower active lanes.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
      localparam logic [WAYS-1:0] LOWER = WAYS'((64'd1 << gi) - 64'd1);
      logic [AW-1:0] rd_idx;
      assign re_ofs[gi] = PW'($countones(i_re & LOWER));
      assign we_ofs[gi] = PW'($countones(i_we & LOWER));
      assign rd_idx     = AW'(head_reg + re_ofs[gi]);
      assign o_data[gi*WIDTH +: WIDTH] = mem[rd_idx];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(STNUM + i);
      for (int c = 0; c < NCK; c++) ckpt_reg[c] <= '0;
      head_reg <= '0;
      tail_reg <= PW'(DEPTH);
      err_reg  <= 1'b0;
    end else begin
      head_reg <= i_kill ? ckpt_reg[i_kill_id] : head_alloc;
      if (i_ckpt_en && !i_kill) ckpt_reg[i_ckpt_id] <= head_alloc;
      if (!overflow) begin
        for (int k = 0; k < WAYS; k++) begin
          if (i_we[k]) mem[AW'(tail_reg + we_ofs[k])] <= i_data[k*WIDTH +: WIDTH];
        end
        tail_reg <= tail_reg + pop_we;
      end
      if (overflow || dup_err) err_reg <= 1'b1;
    end
  end

`ifdef FREELIST_DUPCHK_EN
  localparam int NTAG = 2 ** WIDTH;

  logic [NTAG-1:0] bitmap_reg, bitmap_next;
  // Per checkpoint: tags handed out since that checkpoint, returned to the list on kill.
  logic [NTAG-1:0] since_reg [NCK];
  logic [NTAG-1:0] since_next [NCK];
  logic [NTAG-1:0] alloc_bits, free_bits;

  always_comb begin
    alloc_bits = '0;
    free_bits  = '0;
    dup_err    = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (alloc_ok && i_re[k]) alloc_bits[o_data[k*WIDTH +: WIDTH]] = 1'b1;
      if (i_we[k]) begin
        if (bitmap_reg[i_data[k*WIDTH +: WIDTH]] || free_bits[i_data[k*WIDTH +: WIDTH]])
          dup_err = 1'b1;
        free_bits[i_data[k*WIDTH +: WIDTH]] = 1'b1;
      end
    end
    if (overflow) free_bits = '0;
    if (i_kill) bitmap_next = bitmap_reg | since_reg[i_kill_id] | free_bits;
    else        bitmap_next = (bitmap_reg & ~alloc_bits) | free_bits;
    for (int c = 0; c < NCK; c++) begin
      since_next[c] = since_reg[c] | alloc_bits;
      if (i_kill && (WIDTH_BRM'(c) == i_kill_id)) since_next[c] = '0;
      if (i_ckpt_en && !i_kill && (WIDTH_BRM'(c) == i_ckpt_id)) since_next[c] = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < NTAG; t++)
        bitmap_reg[t] <= (t >= STNUM) && (t < STNUM + DEPTH);
      for (int c = 0; c < NCK; c++) since_reg[c] <= '0;
    end else begin
      bitmap_reg <= bitmap_next;
      for (int c = 0; c < NCK; c++) since_reg[c] <= since_next[c];
    end
  end
`else
  assign dup_err = 1'b0;
`endif

endmodule
